// File: rtl/shift_frame_arbiter_if.sv
// Requester handshake and serial-line bus for shift_frame_arbiter.
// master = producers/line observer side, slave = arbiter side.
interface shift_frame_arbiter_if #(
    parameter int WIDTH = 4
);
    logic             req0_valid;
    logic [WIDTH-1:0] req0_data;
    logic             req0_ready;
    logic             req1_valid;
    logic [WIDTH-1:0] req1_data;
    logic             req1_ready;
    logic             sout;
    logic             sout_valid;
    logic             frame_start;
    logic             frame_done;
    logic             grant_id;
    logic             busy;

    modport master (
        output req0_valid, req0_data, req1_valid, req1_data,
        input  req0_ready, req1_ready, sout, sout_valid,
               frame_start, frame_done, grant_id, busy
    );

    modport slave (
        input  req0_valid, req0_data, req1_valid, req1_data,
        output req0_ready, req1_ready, sout, sout_valid,
               frame_start, frame_done, grant_id, busy
    );
endinterface

// File: rtl/shift_frame_arbiter.sv
// Round-robin arbiter feeding an LSB-first serial shift register.
// One frame = WIDTH shifted bits, then GAP idle cycles, then at least one
// IDLE cycle in which the next requester can be accepted.
module shift_frame_arbiter #(
    parameter int WIDTH = 4,
    parameter int GAP   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    shift_frame_arbiter_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [CW-1:0] LAST   = CW'(WIDTH - 1);
    localparam logic [GW-1:0] GAP_LD = GW'((GAP > 0) ? GAP - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] shreg_q;
    logic [CW-1:0]    cnt_q;
    logic [GW-1:0]    gap_q;
    logic             rr_q;
    logic             grant_q;

    logic idle, in_shift, gnt0, gnt1;

    // Grant decode: a lone requester wins, a tie goes to the rr pointer.
    always_comb begin
        idle     = (state_q == S_IDLE);
        in_shift = (state_q == S_SHIFT);
        gnt0     = bus.req0_valid & (~bus.req1_valid | ~rr_q);
        gnt1     = bus.req1_valid & (~bus.req0_valid |  rr_q);
    end

    // ready is only offered in IDLE and never while reset is held.
    assign bus.req0_ready  = rst & idle & gnt0;
    assign bus.req1_ready  = rst & idle & gnt1;
    assign bus.sout        = in_shift & shreg_q[0];
    assign bus.sout_valid  = in_shift;
    assign bus.frame_start = in_shift & (cnt_q == '0);
    assign bus.frame_done  = in_shift & (cnt_q == LAST);
    assign bus.grant_id    = grant_q;
    assign bus.busy        = ~idle;

    // Frame sequencer: accept, shift out, enforce gap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            gap_q   <= '0;
            rr_q    <= 1'b0;
            grant_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (gnt0) begin
                        shreg_q <= bus.req0_data;
                        grant_q <= 1'b0;
                        rr_q    <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= S_SHIFT;
                    end else if (gnt1) begin
                        shreg_q <= bus.req1_data;
                        grant_q <= 1'b1;
                        rr_q    <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    shreg_q <= {1'b0, shreg_q[WIDTH-1:1]};
                    cnt_q   <= cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        cnt_q <= '0;
                        if (GAP > 0) begin
                            gap_q   <= GAP_LD;
                            state_q <= S_GAP;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end
                end
                S_GAP: begin
                    if (gap_q == '0) state_q <= S_IDLE;
                    else             gap_q   <= gap_q - 1'b1;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_shift_frame_arbiter.sv
// Directed bench: one GAP=1 instance for most scenarios, one GAP=0 instance
// for the back-to-back period check. Inputs driven and outputs sampled on
// the falling edge.
module tb_shift_frame_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    shift_frame_arbiter_if #(.WIDTH(4)) bus_a ();
    shift_frame_arbiter_if #(.WIDTH(4)) bus_b ();

    shift_frame_arbiter #(.WIDTH(4), .GAP(1)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    shift_frame_arbiter #(.WIDTH(4), .GAP(0)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    // One shift cycle of dut_a: bit value, start/done flags and owner.
    task automatic chk_a_bit(input string nm, input int i, input logic b, input logic g);
        logic [5:0] got, exp;
        got = {bus_a.sout, bus_a.sout_valid, bus_a.frame_start, bus_a.frame_done, bus_a.grant_id, bus_a.busy};
        exp = {b, 1'b1, (i == 0), (i == 3), g, 1'b1};
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s bit%0d: got {sout,vld,st,dn,gid,busy}=%b want %b", nm, i, got, exp);
        end
    endtask

    task automatic test_reset();
        bus_a.req0_valid = 1'b1; bus_a.req0_data = 4'hF;
        bus_a.req1_valid = 1'b1; bus_a.req1_data = 4'hF;
        bus_b.req0_valid = 1'b0; bus_b.req0_data = 4'h0;
        bus_b.req1_valid = 1'b0; bus_b.req1_data = 4'h0;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if ({bus_a.req0_ready, bus_a.req1_ready, bus_a.sout, bus_a.sout_valid, bus_a.frame_start,
             bus_a.frame_done, bus_a.grant_id, bus_a.busy} !== 8'b0) begin
            bad++;
            $display("FAIL reset_outputs: got %b want 00000000",
                {bus_a.req0_ready, bus_a.req1_ready, bus_a.sout, bus_a.sout_valid, bus_a.frame_start,
                 bus_a.frame_done, bus_a.grant_id, bus_a.busy});
        end
        bus_a.req0_valid = 1'b0; bus_a.req1_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        logic [3:0] pat;
        pat = 4'b1011;
        bus_a.req0_valid = 1'b1; bus_a.req0_data = pat;
        #1;
        total++;
        if ({bus_a.req0_ready, bus_a.req1_ready, bus_a.busy} !== 3'b100) begin
            bad++;
            $display("FAIL single_ready: got r0,r1,busy=%b want 100", {bus_a.req0_ready, bus_a.req1_ready, bus_a.busy});
        end
        @(negedge clk);
        bus_a.req0_valid = 1'b0; bus_a.req0_data = 4'h0;
        for (int i = 0; i < 4; i++) begin
            chk_a_bit("single", i, pat[i], 1'b0);
            @(negedge clk);
        end
        total++;
        if ({bus_a.busy, bus_a.sout_valid, bus_a.sout} !== 3'b100) begin
            bad++;
            $display("FAIL single_gap: got busy,vld,sout=%b want 100", {bus_a.busy, bus_a.sout_valid, bus_a.sout});
        end
        @(negedge clk);
        total++;
        if ({bus_a.busy, bus_a.sout_valid, bus_a.grant_id} !== 3'b000) begin
            bad++;
            $display("FAIL single_idle: got busy,vld,gid=%b want 000", {bus_a.busy, bus_a.sout_valid, bus_a.grant_id});
        end
    endtask

    // Fresh reset so the rr pointer starts at 0, then three 6-cycle frames.
    task automatic test_alternate();
        logic [3:0] d0, d1, pat;
        logic g;
        d0 = 4'hA; d1 = 4'h5;
        rst = 1'b0; @(negedge clk); rst = 1'b1; @(negedge clk);
        bus_a.req0_valid = 1'b1; bus_a.req0_data = d0;
        bus_a.req1_valid = 1'b1; bus_a.req1_data = d1;
        for (int f = 0; f < 3; f++) begin
            g = f[0];
            pat = g ? d1 : d0;
            #1;
            total++;
            if ({bus_a.req0_ready, bus_a.req1_ready} !== {~g, g}) begin
                bad++;
                $display("FAIL alt_ready f%0d: got r0,r1=%b want %b", f, {bus_a.req0_ready, bus_a.req1_ready}, {~g, g});
            end
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                chk_a_bit("alt", i, pat[i], g);
                total++;
                if ({bus_a.req0_ready, bus_a.req1_ready} !== 2'b00) begin
                    bad++;
                    $display("FAIL alt_ready_shift f%0d: got %b want 00", f, {bus_a.req0_ready, bus_a.req1_ready});
                end
                @(negedge clk);
            end
            @(negedge clk);
        end
        bus_a.req0_valid = 1'b0; bus_a.req1_valid = 1'b0;
    endtask

    task automatic test_only_req1();
        logic [3:0] pat;
        pat = 4'h6;
        bus_a.req1_valid = 1'b1; bus_a.req1_data = pat;
        for (int f = 0; f < 2; f++) begin
            #1;
            total++;
            if ({bus_a.req0_ready, bus_a.req1_ready} !== 2'b01) begin
                bad++;
                $display("FAIL req1_only_ready f%0d: got %b want 01", f, {bus_a.req0_ready, bus_a.req1_ready});
            end
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                chk_a_bit("req1_only", i, pat[i], 1'b1);
                @(negedge clk);
            end
            @(negedge clk);
        end
        bus_a.req1_valid = 1'b0;
    endtask

    task automatic test_data_change();
        logic [3:0] pat;
        pat = 4'h3;
        bus_a.req0_valid = 1'b1; bus_a.req0_data = pat;
        @(negedge clk);
        bus_a.req0_data = 4'hC;
        for (int i = 0; i < 5; i++) begin
            if (i < 4) chk_a_bit("hold", i, pat[i], 1'b0);
            total++;
            if (bus_a.req0_ready !== 1'b0) begin
                bad++;
                $display("FAIL hold_ready c%0d: got %b want 0", i, bus_a.req0_ready);
            end
            @(negedge clk);
        end
        bus_a.req0_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        bus_a.req0_valid = 1'b1; bus_a.req0_data = 4'hF;
        @(negedge clk);
        bus_a.req0_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk_a_bit("mid", 2, 1'b1, 1'b0);
        #1 rst = 1'b0;
        #1;
        total++;
        if ({bus_a.sout, bus_a.sout_valid, bus_a.busy} !== 3'b000) begin
            bad++;
            $display("FAIL mid_async: got sout,vld,busy=%b want 000", {bus_a.sout, bus_a.sout_valid, bus_a.busy});
        end
        bus_a.req0_valid = 1'b1; bus_a.req0_data = 4'h1;
        bus_a.req1_valid = 1'b1; bus_a.req1_data = 4'h0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        total++;
        if ({bus_a.req0_ready, bus_a.req1_ready, bus_a.busy} !== 3'b100) begin
            bad++;
            $display("FAIL mid_rr: got r0,r1,busy=%b want 100", {bus_a.req0_ready, bus_a.req1_ready, bus_a.busy});
        end
        @(negedge clk);
        bus_a.req0_valid = 1'b0; bus_a.req1_valid = 1'b0;
        chk_a_bit("mid_restart", 0, 1'b1, 1'b0);
        repeat (5) @(negedge clk);
    endtask

    // GAP=0: exactly one IDLE cycle between frames, period 5.
    task automatic test_back_to_back();
        logic [3:0] d0, d1, pat;
        logic g;
        d0 = 4'hA; d1 = 4'h5;
        bus_b.req0_valid = 1'b1; bus_b.req0_data = d0;
        bus_b.req1_valid = 1'b1; bus_b.req1_data = d1;
        for (int f = 0; f < 3; f++) begin
            g = f[0];
            pat = g ? d1 : d0;
            #1;
            total++;
            if ({bus_b.req0_ready, bus_b.req1_ready, bus_b.sout_valid, bus_b.busy} !== {~g, g, 2'b00}) begin
                bad++;
                $display("FAIL b2b_idle f%0d: got r0,r1,vld,busy=%b want %b", f,
                    {bus_b.req0_ready, bus_b.req1_ready, bus_b.sout_valid, bus_b.busy}, {~g, g, 2'b00});
            end
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                total++;
                if ({bus_b.sout, bus_b.sout_valid, bus_b.frame_start, bus_b.frame_done, bus_b.grant_id}
                    !== {pat[i], 1'b1, (i == 0), (i == 3), g}) begin
                    bad++;
                    $display("FAIL b2b_bit f%0d b%0d: got %b want %b", f, i,
                        {bus_b.sout, bus_b.sout_valid, bus_b.frame_start, bus_b.frame_done, bus_b.grant_id},
                        {pat[i], 1'b1, (i == 0), (i == 3), g});
                end
                @(negedge clk);
            end
        end
        bus_b.req0_valid = 1'b0; bus_b.req1_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_alternate();
        test_only_req1();
        test_data_change();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
